// File: rtl/n64_poll_sequencer.sv
// N64 controller poll sequencer: probes with STATUS until a pad answers, then
// issues POLL once per period and publishes the reply as the button word.
`timescale 1ns/1ps
module n64_poll_sequencer #(
  parameter int unsigned POLL_PERIOD = 200000,
  parameter int unsigned RX_TIMEOUT  = 2000,
  parameter int unsigned START_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  cmd_byte,
  output logic        cmd_en,
  input  logic        cmd_busy,
  output logic        rx_en,
  input  logic        rx_bit_valid,
  input  logic        rx_bit,
  output logic [31:0] buttons,
  output logic        buttons_valid,
  output logic        connected,
  output logic [7:0]  fault_count
);

  localparam int PW   = $clog2(POLL_PERIOD);
  localparam int TMAX = (RX_TIMEOUT > START_WAIT) ? int'(RX_TIMEOUT) : int'(START_WAIT);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] RX_LOAD     = TW'(RX_TIMEOUT - 1);
  localparam logic [TW-1:0] START_LOAD  = TW'(START_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SEND       = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_TX    = 3'd3,
    S_RECV       = 3'd4,
    S_DONE       = 3'd5,
    S_FAULT      = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  count_q, count_d;
  logic [5:0]  nbits_q, nbits_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        cmd_en_q, cmd_en_d;
  logic        rx_en_q, rx_en_d;
  logic [31:0] buttons_q, buttons_d;
  logic        buttons_valid_q, buttons_valid_d;
  logic        connected_q, connected_d;
  logic [7:0]  fault_count_q, fault_count_d;
  logic        tick_s;
  logic [5:0]  count_inc_s;

  // Next-state and datapath; the timer counts down from LOAD and expires at zero.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    shift_d         = shift_q;
    count_d         = count_q;
    nbits_d         = nbits_q;
    cmd_byte_d      = cmd_byte_q;
    buttons_d       = buttons_q;
    buttons_valid_d = 1'b0;
    connected_d     = connected_q;
    fault_count_d   = fault_count_q;
    count_inc_s     = count_q + 6'd1;
    tick_s          = (period_q == PERIOD_LAST);
    if (tick_s) begin
      period_d = '0;
    end else begin
      period_d = period_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tick_s) begin
          state_d    = S_SEND;
          cmd_byte_d = connected_q ? 8'h01 : 8'h00;
          nbits_d    = connected_q ? 6'd32 : 6'd24;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        state_d = S_WAIT_START;
        timer_d = START_LOAD;
      end
      S_WAIT_START: begin
        if (cmd_busy) begin
          state_d = S_WAIT_TX;
        end else if (timer_q == '0) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_WAIT_TX: begin
        if (!cmd_busy) begin
          state_d = S_RECV;
          shift_d = 32'h0000_0000;
          count_d = 6'd0;
          timer_d = RX_LOAD;
        end else begin
          state_d = S_WAIT_TX;
        end
      end
      S_RECV: begin
        if (rx_bit_valid) begin
          shift_d = {shift_q[30:0], rx_bit};
          count_d = count_inc_s;
          timer_d = RX_LOAD;
          if (count_inc_s == nbits_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RECV;
          end
        end else if (timer_q == '0) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (cmd_byte_q == 8'h01) begin
          buttons_d       = shift_q;
          buttons_valid_d = 1'b1;
        end else begin
          connected_d = 1'b1;
        end
      end
      S_FAULT: begin
        state_d     = S_IDLE;
        connected_d = 1'b0;
        if (fault_count_q != 8'hFF) begin
          fault_count_d = fault_count_q + 8'd1;
        end else begin
          fault_count_d = fault_count_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered from the next state so they align with the state they belong to.
    cmd_en_d = (state_d == S_SEND);
    rx_en_d  = (state_d == S_RECV);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      period_q        <= '0;
      timer_q         <= '0;
      shift_q         <= 32'h0000_0000;
      count_q         <= 6'd0;
      nbits_q         <= 6'd24;
      cmd_byte_q      <= 8'h00;
      cmd_en_q        <= 1'b0;
      rx_en_q         <= 1'b0;
      buttons_q       <= 32'h0000_0000;
      buttons_valid_q <= 1'b0;
      connected_q     <= 1'b0;
      fault_count_q   <= 8'h00;
    end else begin
      state_q         <= state_d;
      period_q        <= period_d;
      timer_q         <= timer_d;
      shift_q         <= shift_d;
      count_q         <= count_d;
      nbits_q         <= nbits_d;
      cmd_byte_q      <= cmd_byte_d;
      cmd_en_q        <= cmd_en_d;
      rx_en_q         <= rx_en_d;
      buttons_q       <= buttons_d;
      buttons_valid_q <= buttons_valid_d;
      connected_q     <= connected_d;
      fault_count_q   <= fault_count_d;
    end
  end

  assign cmd_byte      = cmd_byte_q;
  assign cmd_en        = cmd_en_q;
  assign rx_en         = rx_en_q;
  assign buttons       = buttons_q;
  assign buttons_valid = buttons_valid_q;
  assign connected     = connected_q;
  assign fault_count   = fault_count_q;

endmodule
